mem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single data port of the memory controller in the alpha-composition ASIP. It shares the port between two requesters:
- the vector core, which issues scalar or vector reads and writes;
- a read-only pixel stream engine, which issues 128-bit vector reads of the composed image.

The block serialises the two requesters into one memory command at a time, applies fixed core priority with a starvation guard for the stream, and returns read data and acknowledges to the winner.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundled handshake and memory-port signals shared by the arbiter and its environment.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              core_req;
    logic              core_we;
    logic              core_vf;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wd;
    logic [DATA_W-1:0] core_rd;
    logic              core_ack;

    logic              strm_req;
    logic [ADDR_W-1:0] strm_addr;
    logic [DATA_W-1:0] strm_rd;
    logic              strm_ack;

    logic              mem_we;
    logic              mem_vf;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    logic              busy;

    modport slave (
        input  core_req, core_we, core_vf, core_addr, core_wd,
        input  strm_req, strm_addr,
        input  mem_rd,
        output core_rd, core_ack, strm_rd, strm_ack,
        output mem_we, mem_vf, mem_addr, mem_wd,
        output busy
    );

    modport master (
        output core_req, core_we, core_vf, core_addr, core_wd,
        output strm_req, strm_addr,
        output mem_rd,
        input  core_rd, core_ack, strm_rd, strm_ack,
        input  mem_we, mem_vf, mem_addr, mem_wd,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the memory data port: vector core (read/write) and pixel stream (read-only).
// Core has fixed priority; a wait counter lets the stream in after MAX_WAIT consecutive core grants.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t            state_q;
    logic              owner_q;      // 1 = stream owns the current access
    logic [3:0]        wait_q;
    logic [3:0]        wait_d;
    logic              strm_win;
    logic              mem_we_q;
    logic              mem_vf_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wd_q;
    logic              core_ack_q;
    logic              strm_ack_q;
    logic              busy_q;

    always_comb begin
        strm_win = bus.strm_req && (!bus.core_req || (wait_q == WAIT_MAX));
        wait_d   = wait_q;
        if (strm_win || !bus.strm_req) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wait_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_vf_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            core_ack_q <= 1'b0;
            strm_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_q <= wait_d;
                    if (bus.core_req || bus.strm_req) begin
                        owner_q <= strm_win;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                        if (strm_win) begin
                            mem_we_q   <= 1'b0;
                            mem_vf_q   <= 1'b1;
                            mem_addr_q <= bus.strm_addr;
                            mem_wd_q   <= '0;
                        end else begin
                            mem_we_q   <= bus.core_we;
                            mem_vf_q   <= bus.core_vf;
                            mem_addr_q <= bus.core_addr;
                            mem_wd_q   <= bus.core_wd;
                        end
                    end
                end
                ISSUE: begin
                    mem_we_q   <= 1'b0;
                    core_ack_q <= !owner_q;
                    strm_ack_q <= owner_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    core_ack_q <= 1'b0;
                    strm_ack_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is a pass-through of the registered memory output, gated by the owner's ack.
    assign bus.core_rd  = core_ack_q ? bus.mem_rd : '0;
    assign bus.strm_rd  = strm_ack_q ? bus.mem_rd : '0;
    assign bus.core_ack = core_ack_q;
    assign bus.strm_ack = strm_ack_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_vf   = mem_vf_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read memory.
// Expected values are hand-computed constants for each scenario.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(128)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(128), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [127:0] mem [logic [31:0]];

    // Memory: write commits on the edge, read data registered one cycle after address.
    always @(posedge clk) begin
        logic [127:0] word;
        word = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : '0;
        bus.mem_rd <= bus.mem_vf ? word : {96'b0, word[31:0]};
        if (bus.mem_we)
            mem[bus.mem_addr] = bus.mem_vf ? bus.mem_wd : {word[127:32], bus.mem_wd[31:0]};
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_core(input string tag, input logic we, input logic vf,
                            input logic [31:0] addr, input logic [127:0] wd,
                            input logic [127:0] exp_rd);
        int cyc    = 0;
        int we_cnt = 0;
        @(negedge clk);
        bus.core_req  = 1'b1;
        bus.core_we   = we;
        bus.core_vf   = vf;
        bus.core_addr = addr;
        bus.core_wd   = wd;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (i == 1) begin
                check_eq({tag, "_issue_vf"}, 128'(bus.mem_vf), 128'(vf));
                check_eq({tag, "_issue_addr"}, 128'(bus.mem_addr), 128'(addr));
            end
            if (bus.core_ack) begin
                cyc = i;
                if (!we) check_eq({tag, "_rd"}, bus.core_rd, exp_rd);
                check_eq({tag, "_strm_rd"}, bus.strm_rd, '0);
                break;
            end
        end
        bus.core_req = 1'b0;
        check_eq({tag, "_latency"}, 128'(cyc), 128'(2));
        check_eq({tag, "_we_cycles"}, 128'(we_cnt), 128'(we ? 1 : 0));
    endtask

    localparam logic [127:0] VEC     = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] W8      = 128'h11111111_22222222_33333333_DEADBEEF;
    localparam logic [127:0] W40     = 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004;
    localparam logic [127:0] W200    = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
    localparam logic [127:0] W8_SCAL = {96'b0, 32'hDEADBEEF};

    initial begin
        int c_cyc;
        int s_cyc;
        int n_acks;
        int bad_we;
        int bad_vf;
        int s_ack_cyc [3];
        logic order [15];

        rst           = 1'b0;
        bus.core_req  = 1'b0;
        bus.core_we   = 1'b0;
        bus.core_vf   = 1'b0;
        bus.core_addr = '0;
        bus.core_wd   = '0;
        bus.strm_req  = 1'b0;
        bus.strm_addr = '0;
        mem[32'h8]    = W8;
        mem[32'h40]   = W40;
        mem[32'h200]  = W200;
        repeat (3) @(negedge clk);

        check_eq("rst_core_ack", 128'(bus.core_ack), '0);
        check_eq("rst_strm_ack", 128'(bus.strm_ack), '0);
        check_eq("rst_busy", 128'(bus.busy), '0);
        check_eq("rst_mem_we", 128'(bus.mem_we), '0);
        check_eq("rst_mem_vf", 128'(bus.mem_vf), '0);
        check_eq("rst_mem_addr", 128'(bus.mem_addr), '0);
        check_eq("rst_mem_wd", bus.mem_wd, '0);
        check_eq("rst_core_rd", bus.core_rd, '0);
        check_eq("rst_strm_rd", bus.strm_rd, '0);

        // Both requesters rise together out of reset: core first, then stream.
        rst           = 1'b1;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_vf   = 1'b0;
        bus.core_addr = 32'h8;
        bus.strm_req  = 1'b1;
        bus.strm_addr = 32'h40;
        c_cyc = 0;
        s_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check_eq("sim_busy_issue", 128'(bus.busy), 128'(1));
            if (bus.core_ack) begin
                c_cyc = i;
                check_eq("sim_core_rd", bus.core_rd, W8_SCAL);
                bus.core_req = 1'b0;
            end
            if (bus.strm_ack) begin
                s_cyc = i;
                check_eq("sim_strm_rd", bus.strm_rd, W40);
                bus.strm_req = 1'b0;
            end
            if (c_cyc != 0 && s_cyc != 0) break;
        end
        check_eq("sim_core_ack_cycle", 128'(c_cyc), 128'(2));
        check_eq("sim_strm_ack_cycle", 128'(s_cyc), 128'(5));

        run_core("vec_wr", 1'b1, 1'b1, 32'd120000, VEC, '0);
        check_eq("vec_wr_mem", mem[32'd120000], VEC);
        run_core("vec_rd", 1'b0, 1'b1, 32'd120000, '0, VEC);
        run_core("scal_rd", 1'b0, 1'b0, 32'h8, '0, W8_SCAL);

        // Stream alone, request held across three accesses.
        @(negedge clk);
        bus.strm_req  = 1'b1;
        bus.strm_addr = 32'h40;
        n_acks = 0;
        bad_we = 0;
        bad_vf = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_we) bad_we++;
            if (!bus.mem_vf) bad_vf++;
            if (bus.strm_ack) begin
                s_ack_cyc[n_acks] = i;
                check_eq($sformatf("strm_rd%0d", n_acks), bus.strm_rd, W40);
                check_eq($sformatf("strm_core_rd%0d", n_acks), bus.core_rd, '0);
                n_acks++;
                if (n_acks == 3) break;
            end
        end
        bus.strm_req = 1'b0;
        check_eq("strm_acks", 128'(n_acks), 128'(3));
        check_eq("strm_ack0_cycle", 128'(s_ack_cyc[0]), 128'(2));
        check_eq("strm_ack1_cycle", 128'(s_ack_cyc[1]), 128'(5));
        check_eq("strm_ack2_cycle", 128'(s_ack_cyc[2]), 128'(8));
        check_eq("strm_mem_we_seen", 128'(bad_we), '0);
        check_eq("strm_mem_vf_low", 128'(bad_vf), '0);

        // Both held continuously: C,C,C,C,S repeated.
        @(negedge clk);
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_vf   = 1'b1;
        bus.core_addr = 32'd120000;
        bus.strm_req  = 1'b1;
        bus.strm_addr = 32'h40;
        n_acks = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.core_ack || bus.strm_ack) begin
                order[n_acks] = bus.strm_ack;
                if (bus.core_ack) check_eq($sformatf("starve_core_rd%0d", n_acks), bus.core_rd, VEC);
                n_acks++;
                if (n_acks == 15) break;
            end
        end
        bus.core_req = 1'b0;
        bus.strm_req = 1'b0;
        check_eq("starve_acks", 128'(n_acks), 128'(15));
        for (int k = 0; k < 15; k++)
            check_eq($sformatf("starve_grant%0d", k), 128'(order[k]), 128'((k % 5) == 4));

        // Reset lands in the ISSUE cycle of a core write.
        @(negedge clk);
        @(negedge clk);
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b1;
        bus.core_vf   = 1'b1;
        bus.core_addr = 32'h200;
        bus.core_wd   = VEC;
        @(negedge clk);
        check_eq("abort_we_in_issue", 128'(bus.mem_we), 128'(1));
        #1 rst = 1'b0;
        #1;
        check_eq("abort_we_async", 128'(bus.mem_we), '0);
        check_eq("abort_busy_async", 128'(bus.busy), '0);
        @(negedge clk);
        bus.core_req = 1'b0;
        rst          = 1'b1;
        n_acks = 0;
        bad_we = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.core_ack) n_acks++;
            if (bus.busy) bad_we++;
        end
        check_eq("abort_no_ack", 128'(n_acks), '0);
        check_eq("abort_idle_busy", 128'(bad_we), '0);
        check_eq("abort_mem_kept", mem[32'h200], W200);
        run_core("post_abort_rd", 1'b0, 1'b1, 32'h200, '0, W200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
